// File: rtl/pe_array_pkg.sv
// pe_array_pkg: shared definitions for the PE array controller.
//   - state_t      : FSM state encoding (IDLE is the all-zero reset value)
//   - DIM_DEF      : default array side length
//   - FEED_LEN     : FEED phase length for DIM_DEF (2*DIM-1)
//   - DRAIN_LEN    : DRAIN phase length for DIM_DEF (DIM-1)
//   - *_f helpers  : the same lengths for an arbitrary DIM parameter
package pe_array_pkg;

  localparam int DIM_DEF   = 4;
  localparam int FEED_LEN  = 2 * DIM_DEF - 1;
  localparam int DRAIN_LEN = DIM_DEF - 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_FEED    = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_READOUT = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  function automatic int feed_len_f(input int dim);
    return 2 * dim - 1;
  endfunction

  function automatic int drain_len_f(input int dim);
    return dim - 1;
  endfunction

  // Step counter width: must hold 0..2*DIM-2 and also the value DIM,
  // which the skew generator compares against.
  function automatic int step_w_f(input int dim);
    return $clog2(2 * dim);
  endfunction

endpackage

// File: rtl/skew_gen.sv
// skew_gen: combinational operand skew for a systolic array.
//   step_i    : FEED step t
//   lane_en_o : lane i valid when 0 <= t-i < DIM
//   lane_k_o  : lane i operand index t-i in bits [i*KW +: KW], 0 when invalid
module skew_gen #(
  parameter int DIM = 4,
  parameter int KW  = 2,
  parameter int SW  = 3
) (
  input  logic [SW-1:0]     step_i,
  output logic [DIM-1:0]    lane_en_o,
  output logic [DIM*KW-1:0] lane_k_o
);

  genvar gi;
  generate
    for (gi = 0; gi < DIM; gi++) begin : g_lane
      logic [SW-1:0] diff;
      // diff wraps when t < i; the first term of lane_en rejects that case
      assign diff          = step_i - SW'(gi);
      assign lane_en_o[gi] = (step_i >= SW'(gi)) && (diff < SW'(DIM));
      assign lane_k_o[gi*KW +: KW] = lane_en_o[gi] ? diff[KW-1:0] : '0;
    end
  endgenerate

endmodule

// File: rtl/pe_array_ctrl.sv
// pe_array_ctrl: sequencer for one matrix-multiply pass on a DIM x DIM PE array.
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   start_i, abort_i    : begin a pass (IDLE only) / cancel a running pass
//   busy_o              : not IDLE
//   pe_clr_o            : accumulator clear (CLEAR)
//   feed_en_o           : array advance (FEED and DRAIN)
//   lane_en_o, lane_k_o : skewed per-lane operand valid/index (FEED)
//   res_row_o, res_valid_o, res_ready_i : row readout handshake (READOUT)
//   done_o              : one-cycle completion pulse (DONE)
// Every output is a register loaded from the next-state values, so outputs
// line up with the state they describe and no input reaches an output
// without passing a flop.
module pe_array_ctrl
  import pe_array_pkg::*;
#(
  parameter int DIM = DIM_DEF,
  parameter int KW  = $clog2(DIM)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              abort_i,
  output logic              busy_o,
  output logic              pe_clr_o,
  output logic              feed_en_o,
  output logic [DIM-1:0]    lane_en_o,
  output logic [DIM*KW-1:0] lane_k_o,
  output logic [KW-1:0]     res_row_o,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic              done_o
);

  localparam int FEED_L  = feed_len_f(DIM);
  localparam int DRAIN_L = drain_len_f(DIM);
  localparam int SW      = step_w_f(DIM);

  state_t          state_reg, state_next;
  logic [SW-1:0]   step_reg, step_next;
  logic [KW-1:0]   row_reg, row_next;
  logic [DIM-1:0]    lane_en_c;
  logic [DIM*KW-1:0] lane_k_c;

  always_comb begin
    state_next = state_reg;
    step_next  = step_reg;
    row_next   = row_reg;
    if (abort_i && state_reg != ST_IDLE) begin
      state_next = ST_IDLE;
      step_next  = '0;
      row_next   = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          step_next = '0;
          row_next  = '0;
          if (start_i) state_next = ST_CLEAR;
        end
        ST_CLEAR: begin
          state_next = ST_FEED;
          step_next  = '0;
        end
        ST_FEED: begin
          if (step_reg == SW'(FEED_L - 1)) begin
            state_next = ST_DRAIN;
            step_next  = '0;
          end else begin
            step_next = step_reg + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (step_reg == SW'(DRAIN_L - 1)) begin
            state_next = ST_READOUT;
            step_next  = '0;
            row_next   = '0;
          end else begin
            step_next = step_reg + 1'b1;
          end
        end
        ST_READOUT: begin
          if (res_ready_i) begin
            if (row_reg == KW'(DIM - 1)) begin
              state_next = ST_DONE;
              row_next   = '0;
            end else begin
              row_next = row_reg + 1'b1;
            end
          end
        end
        ST_DONE: state_next = ST_IDLE;
        default: begin
          state_next = ST_IDLE;
          step_next  = '0;
          row_next   = '0;
        end
      endcase
    end
  end

  // Skew is computed for the step about to be entered so the registered
  // lane outputs appear in the same cycle as that FEED step.
  skew_gen #(
    .DIM(DIM),
    .KW (KW),
    .SW (SW)
  ) u_skew (
    .step_i   (step_next),
    .lane_en_o(lane_en_c),
    .lane_k_o (lane_k_c)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg   <= ST_IDLE;
      step_reg    <= '0;
      row_reg     <= '0;
      busy_o      <= 1'b0;
      pe_clr_o    <= 1'b0;
      feed_en_o   <= 1'b0;
      lane_en_o   <= '0;
      lane_k_o    <= '0;
      res_row_o   <= '0;
      res_valid_o <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      state_reg   <= state_next;
      step_reg    <= step_next;
      row_reg     <= row_next;
      busy_o      <= (state_next != ST_IDLE);
      pe_clr_o    <= (state_next == ST_CLEAR);
      feed_en_o   <= (state_next == ST_FEED) || (state_next == ST_DRAIN);
      lane_en_o   <= (state_next == ST_FEED) ? lane_en_c : '0;
      lane_k_o    <= (state_next == ST_FEED) ? lane_k_c : '0;
      res_row_o   <= (state_next == ST_READOUT) ? row_next : '0;
      res_valid_o <= (state_next == ST_READOUT);
      done_o      <= (state_next == ST_DONE);
    end
  end

endmodule

// File: tb/tb_pe_array_ctrl.sv
// tb_pe_array_ctrl: self-checking bench for pe_array_ctrl (DIM=4).
// The reference model tracks a pass as "active + cycle offset since CLEAR +
// current readout row + done flag" and derives every output from the phase
// lengths and the skew formula.
module tb_pe_array_ctrl;
  import pe_array_pkg::*;

  localparam int D  = 4;
  localparam int KW = 2;
  localparam int OW = 3 + D + D * KW + KW + 2;

  logic clk = 1'b0;
  logic rst, start, abort, ready;
  logic          busy_o, pe_clr_o, feed_en_o, res_valid_o, done_o;
  logic [D-1:0]  lane_en_o;
  logic [D*KW-1:0] lane_k_o;
  logic [KW-1:0] res_row_o;
  logic [OW-1:0] obs;

  int vectors = 0;
  int errors  = 0;

  // reference model state
  bit m_active;
  int m_off;
  int m_row;
  bit m_done;

  pe_array_ctrl #(.DIM(D), .KW(KW)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .abort_i    (abort),
    .busy_o     (busy_o),
    .pe_clr_o   (pe_clr_o),
    .feed_en_o  (feed_en_o),
    .lane_en_o  (lane_en_o),
    .lane_k_o   (lane_k_o),
    .res_row_o  (res_row_o),
    .res_valid_o(res_valid_o),
    .res_ready_i(ready),
    .done_o     (done_o)
  );

  always #5 clk = ~clk;

  assign obs = {busy_o, pe_clr_o, feed_en_o, lane_en_o, lane_k_o,
                res_row_o, res_valid_o, done_o};

  function automatic logic [OW-1:0] model_out();
    logic b, c, f, rv, dn;
    logic [D-1:0]    en;
    logic [D*KW-1:0] k;
    logic [KW-1:0]   row;
    b = 0; c = 0; f = 0; rv = 0; dn = 0; en = '0; k = '0; row = '0;
    if (m_active) begin
      b = 1;
      if (m_done) dn = 1;
      else if (m_off == 0) c = 1;
      else if (m_off <= FEED_LEN) begin
        f = 1;
        for (int i = 0; i < D; i++) begin
          int d;
          d = (m_off - 1) - i;
          if (d >= 0 && d < D) begin
            en[i] = 1'b1;
            k[i*KW +: KW] = KW'(d);
          end
        end
      end else if (m_off <= FEED_LEN + DRAIN_LEN) f = 1;
      else begin
        rv  = 1;
        row = KW'(m_row);
      end
    end
    return {b, c, f, en, k, row, rv, dn};
  endfunction

  function automatic bit in_readout();
    return m_active && !m_done && (m_off > FEED_LEN + DRAIN_LEN);
  endfunction

  // advance the model across one rising edge using the driven inputs
  task automatic model_edge();
    if (rst) begin
      m_active = 0; m_off = 0; m_row = 0; m_done = 0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1; m_off = 0; m_row = 0; m_done = 0;
      end
    end else if (abort || m_done) begin
      m_active = 0; m_off = 0; m_row = 0; m_done = 0;
    end else if (in_readout()) begin
      if (ready) begin
        if (m_row == D - 1) m_done = 1;
        else m_row++;
      end
    end else begin
      m_off++;
    end
  endtask

  task automatic test_reset();
    rst = 1; start = 0; abort = 0; ready = 0;
    m_active = 0; m_off = 0; m_row = 0; m_done = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++;
      if (obs !== model_out()) begin
        errors++;
        $display("FAIL reset c=%0d got=%h exp=%h", c, obs, model_out());
      end
    end
    rst = 0;
  endtask

  task automatic test_full_pass();
    int first_rv;
    first_rv = -1;
    for (int c = 0; c < 20; c++) begin
      vectors++;
      if (obs !== model_out()) begin
        errors++;
        $display("FAIL full_pass c=%0d got=%h exp=%h", c, obs, model_out());
      end
      if (m_active && !m_done && m_off == 4) begin
        vectors++;
        if (lane_en_o !== 4'b1111 || lane_k_o !== 8'b00_01_10_11) begin
          errors++;
          $display("FAIL skew_t3 got en=%b k=%b exp en=1111 k=00011011", lane_en_o, lane_k_o);
        end
      end
      if (m_active && !m_done && m_off == 6) begin
        vectors++;
        if (lane_en_o !== 4'b1100 || lane_k_o !== 8'b10_11_00_00) begin
          errors++;
          $display("FAIL skew_t5 got en=%b k=%b exp en=1100 k=10110000", lane_en_o, lane_k_o);
        end
      end
      if (res_valid_o === 1'b1 && first_rv < 0) first_rv = c;
      start = (c == 0); abort = 0; ready = 1;
      model_edge();
      @(negedge clk);
    end
    vectors++;
    if (first_rv != 3 * D) begin
      errors++;
      $display("FAIL latency got=%0d exp=%0d", first_rv, 3 * D);
    end
  endtask

  task automatic test_backpressure();
    int hold;
    hold = 0;
    for (int c = 0; c < 28; c++) begin
      vectors++;
      if (obs !== model_out()) begin
        errors++;
        $display("FAIL backpressure c=%0d got=%h exp=%h", c, obs, model_out());
      end
      start = (c == 0); abort = 0; ready = 1;
      if (in_readout() && m_row == 2 && hold < 5) begin
        ready = 0;
        hold++;
        vectors++;
        if (res_row_o !== 2'd2 || res_valid_o !== 1'b1) begin
          errors++;
          $display("FAIL hold_row got row=%0d valid=%b exp row=2 valid=1", res_row_o, res_valid_o);
        end
      end
      model_edge();
      @(negedge clk);
    end
  endtask

  task automatic test_abort();
    for (int c = 0; c < 34; c++) begin
      vectors++;
      if (obs !== model_out()) begin
        errors++;
        $display("FAIL abort c=%0d got=%h exp=%h", c, obs, model_out());
      end
      // abort together with start in IDLE must not block the start
      start = (c == 0) || (c == 10);
      abort = (c == 0) || (m_active && !m_done && m_off == 5 && c < 10);
      ready = 1;
      model_edge();
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 12; c++) begin
      vectors++;
      if (obs !== model_out()) begin
        errors++;
        $display("FAIL reset_mid c=%0d got=%h exp=%h", c, obs, model_out());
      end
      start = 1; abort = 0; ready = 1;
      if (m_active && !m_done && m_off == FEED_LEN + 2) begin
        rst = 1;
        #1;
        vectors++;
        if (obs !== '0) begin
          errors++;
          $display("FAIL async_reset got=%h exp=0", obs);
        end
        model_edge();
        @(negedge clk);
        rst = 0;
        break;
      end
      model_edge();
      @(negedge clk);
    end
    for (int c = 0; c < 20; c++) begin
      vectors++;
      if (obs !== model_out()) begin
        errors++;
        $display("FAIL after_reset c=%0d got=%h exp=%h", c, obs, model_out());
      end
      start = (c == 0); abort = 0; ready = 1;
      model_edge();
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      vectors++;
      if (obs !== model_out()) begin
        errors++;
        $display("FAIL random c=%0d got=%h exp=%h", c, obs, model_out());
      end
      start = ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 39) == 0);
      ready = ($urandom_range(0, 9) < 6);
      model_edge();
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_full_pass();
    test_backpressure();
    test_abort();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
